// File: rtl/systolic_skew_feeder_pkg.sv
// Shared constants and types for the matrix-multiplier array edge feeders.
package mm_pkg;

  // Default operand width and array dimension, shared with the PE and array top.
  localparam int MM_DATA_WIDTH = 8;
  localparam int MM_N          = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } feeder_state_t;

  // One lane slot: operand element plus its framing flags.
  typedef struct packed {
    logic [MM_DATA_WIDTH-1:0] data;
    logic                     valid;
    logic                     first;
    logic                     last;
  } lane_beat_t;

endpackage

// File: rtl/systolic_skew_feeder_lane_delay.sv
// Fixed-depth shift register carrying one lane's {data, valid, first, last}.
// WIDTH defaults to the packed lane_beat_t; the feeder passes its own width
// so non-default operand widths pack the same field order.
module lane_delay
  import mm_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int WIDTH = $bits(lane_beat_t)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift one slot per cycle; reset empties the whole line so partial frames vanish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
    end else begin
      stage[0] <= d;
      for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Edge feeder for the systolic array: skews each accepted vector so lane i
// lags lane 0 by i cycles, and holds off new input until the last beat of a
// frame has drained out of lane N-1.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | waiting for a beat with in_first; other beats are dropped
//   STREAM | inside a frame, every handshake beat enters the lanes
//   FLUSH  | last beat taken, in_ready low while it skews out to lane N-1
module systolic_skew_feeder
  import mm_pkg::*;
#(
  parameter int DATA_WIDTH = MM_DATA_WIDTH,
  parameter int N          = MM_N
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*DATA_WIDTH-1:0] in_data,
  input  logic                  in_first,
  input  logic                  in_last,
  output logic [N*DATA_WIDTH-1:0] out_data,
  output logic [N-1:0]          out_valid,
  output logic [N-1:0]          out_first,
  output logic [N-1:0]          out_last,
  output logic                  frame_done
);

  localparam int CW = $clog2(N);
  localparam int BW = DATA_WIDTH + 3;

  feeder_state_t state_q, state_d;
  logic [CW-1:0] flush_cnt_q;
  logic          accept;
  logic          lane_load;
  logic          flush_tc;

  assign accept    = in_valid && in_ready;
  // Beats count toward a frame only once one has been opened by in_first.
  assign lane_load = accept && ((state_q == STREAM) || in_first);
  // Counter walks N-1 .. 1; the step to 0 is the cycle the last element leaves lane N-1.
  assign flush_tc  = (state_q == FLUSH) && (flush_cnt_q == CW'(1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && in_first) state_d = in_last ? FLUSH : STREAM;
      STREAM:  if (accept && in_last)  state_d = FLUSH;
      FLUSH:   if (flush_tc)           state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: input is only blocked while a frame tail drains.
  always_comb begin
    in_ready = (state_q != FLUSH);
  end

  // Flush down-counter and the registered frame_done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt_q <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= flush_tc;
      if ((state_q != FLUSH) && (state_d == FLUSH)) flush_cnt_q <= CW'(N - 1);
      else if (state_q == FLUSH)                     flush_cnt_q <= flush_cnt_q - CW'(1);
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [BW-1:0] lane_d;
    logic [BW-1:0] lane_q;

    // Non-loaded cycles push an empty slot so bubbles skew exactly like data.
    assign lane_d = lane_load ? {in_data[i*DATA_WIDTH +: DATA_WIDTH], 1'b1, in_first, in_last}
                              : '0;

    lane_delay #(.DEPTH(i + 1), .WIDTH(BW)) u_lane (
      .clk (clk),
      .rst (rst),
      .d   (lane_d),
      .q   (lane_q)
    );

    assign out_data[i*DATA_WIDTH +: DATA_WIDTH] = lane_q[BW-1:3];
    assign out_valid[i] = lane_q[2];
    assign out_first[i] = lane_q[1];
    assign out_last[i]  = lane_q[0];
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder (N=4, 8-bit elements).
module tb_systolic_skew_feeder;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N*DW-1:0] in_data = '0;
  logic          in_first = 1'b0;
  logic          in_last = 1'b0;
  logic [N*DW-1:0] out_data;
  logic [N-1:0]  out_valid, out_first, out_last;
  logic          frame_done;

  systolic_skew_feeder #(.DATA_WIDTH(DW), .N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_first   (in_first),
    .in_last    (in_last),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_first  (out_first),
    .out_last   (out_last),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic          v, f, l;
    logic [31:0]   d;
    logic [31:0]   ed;
    logic [3:0]    ev, ef, el;
    logic          edn, erd;
  } row_t;

  row_t rows[$];

  task automatic add(input logic v, f, l, input logic [31:0] d, input logic [31:0] ed,
                     input logic [3:0] ev, ef, el, input logic edn, erd);
    row_t r;
    r.v = v; r.f = f; r.l = l; r.d = d;
    r.ed = ed; r.ev = ev; r.ef = ef; r.el = el; r.edn = edn; r.erd = erd;
    rows.push_back(r);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [N*DW-1:0] d;
    logic [N-1:0]    v, f, l;
  } vrec_t;

  vrec_t vh [N];
  int    edge_n;
  int    block_until;
  int    done_edge;
  bit    in_frame;

  task automatic model_reset();
    for (int i = 0; i < N; i++) vh[i] = '0;
    edge_n = 0; block_until = 0; done_edge = -1; in_frame = 0;
  endtask

  // One clock with the inputs currently driven; model expectations are derived
  // from the frame timing (last beat at E: blocked through E+N-1, done after E+N-1).
  task automatic mtick(output bit loaded);
    vrec_t nv;
    bit take;
    logic [N*DW-1:0] ed;
    logic [N-1:0] ev, ef, el;
    take   = in_valid && (edge_n >= block_until);
    loaded = take && (in_frame || in_first);
    nv = '0;
    if (loaded) begin
      nv.d = in_data; nv.v = '1; nv.f = {N{in_first}}; nv.l = {N{in_last}};
    end
    @(posedge clk);
    for (int i = N - 1; i > 0; i--) vh[i] = vh[i-1];
    vh[0] = nv;
    if (loaded && in_last) begin
      in_frame = 0; block_until = edge_n + N; done_edge = edge_n + N - 1;
    end else if (loaded) begin
      in_frame = 1;
    end
    ed = '0; ev = '0; ef = '0; el = '0;
    for (int i = 0; i < N; i++) begin
      ed[i*DW +: DW] = vh[i].d[i*DW +: DW];
      ev[i] = vh[i].v[i]; ef[i] = vh[i].f[i]; el[i] = vh[i].l[i];
    end
    #1;
    chk("m_data",  out_data,   ed);
    chk("m_valid", out_valid,  ev);
    chk("m_first", out_first,  ef);
    chk("m_last",  out_last,   el);
    chk("m_done",  frame_done, (edge_n == done_edge));
    edge_n++;
    chk("m_ready", in_ready,   (edge_n >= block_until));
  endtask

  task automatic do_reset();
    in_valid = 0; in_first = 0; in_last = 0; in_data = '0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
  endtask

  initial begin
    bit ld;
    int acc_e[5];
    int idx, done_cnt, first_done, beats, cyc, pos, flen;
    int viol[N];
    bit open[N];

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data",  out_data,   '0);
    chk("rst_valid", out_valid,  '0);
    chk("rst_first", out_first,  '0);
    chk("rst_last",  out_last,   '0);
    chk("rst_done",  frame_done, 1'b0);
    chk("rst_ready", in_ready,   1'b1);
    rst = 0;

    // ---- vector table ----
    // dropped beat in IDLE
    add(1,0,0,32'h11111111, 32'h00000000,4'b0000,4'b0000,4'b0000,0,1);
    // three-beat frame
    add(1,1,0,32'h04030201, 32'h00000001,4'b0001,4'b0001,4'b0000,0,1);
    add(1,0,0,32'h08070605, 32'h00000205,4'b0011,4'b0010,4'b0000,0,1);
    add(1,0,1,32'h0C0B0A09, 32'h00030609,4'b0111,4'b0100,4'b0001,0,0);
    add(0,0,0,32'h00000000, 32'h04070A00,4'b1110,4'b1000,4'b0010,0,0);
    add(0,0,0,32'h00000000, 32'h080B0000,4'b1100,4'b0000,4'b0100,0,0);
    add(0,0,0,32'h00000000, 32'h0C000000,4'b1000,4'b0000,4'b1000,1,1);
    add(0,0,0,32'h00000000, 32'h00000000,4'b0000,4'b0000,4'b0000,0,1);
    // bubble between beats 1 and 2
    add(1,1,0,32'h04030201, 32'h00000001,4'b0001,4'b0001,4'b0000,0,1);
    add(1,0,0,32'h08070605, 32'h00000205,4'b0011,4'b0010,4'b0000,0,1);
    add(0,0,0,32'hAAAAAAAA, 32'h00030600,4'b0110,4'b0100,4'b0000,0,1);
    add(1,0,1,32'h0C0B0A09, 32'h04070009,4'b1101,4'b1000,4'b0001,0,0);
    add(0,0,0,32'h00000000, 32'h08000A00,4'b1010,4'b0000,4'b0010,0,0);
    add(0,0,0,32'h00000000, 32'h000B0000,4'b0100,4'b0000,4'b0100,0,0);
    add(0,0,0,32'h00000000, 32'h0C000000,4'b1000,4'b0000,4'b1000,1,1);
    add(0,0,0,32'h00000000, 32'h00000000,4'b0000,4'b0000,4'b0000,0,1);
    // one-beat frame; junk offered during FLUSH must be refused
    add(1,1,1,32'h000180FF, 32'h000000FF,4'b0001,4'b0001,4'b0001,0,0);
    add(1,1,0,32'hDEADBEEF, 32'h00008000,4'b0010,4'b0010,4'b0010,0,0);
    add(1,1,0,32'hDEADBEEF, 32'h00010000,4'b0100,4'b0100,4'b0100,0,0);
    add(1,1,0,32'hDEADBEEF, 32'h00000000,4'b1000,4'b1000,4'b1000,1,1);
    add(0,0,0,32'h00000000, 32'h00000000,4'b0000,4'b0000,4'b0000,0,1);

    foreach (rows[k]) begin
      in_valid = rows[k].v; in_first = rows[k].f; in_last = rows[k].l; in_data = rows[k].d;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_data", k),  out_data,   rows[k].ed);
      chk($sformatf("tbl%0d_valid", k), out_valid,  rows[k].ev);
      chk($sformatf("tbl%0d_first", k), out_first,  rows[k].ef);
      chk($sformatf("tbl%0d_last", k),  out_last,   rows[k].el);
      chk($sformatf("tbl%0d_done", k),  frame_done, rows[k].edn);
      chk($sformatf("tbl%0d_ready", k), in_ready,   rows[k].erd);
    end
    in_valid = 0; in_first = 0; in_last = 0;

    // ---- back-to-back frames with in_valid held high ----
    idx = 0; done_cnt = 0; first_done = -1;
    for (int i = 0; i < N; i++) begin viol[i] = 0; open[i] = 0; end
    for (int i = 0; i < 5; i++) acc_e[i] = -100;
    for (int c = 0; c < 20; c++) begin
      bit acc_now;
      in_valid = (idx < 5);
      in_first = (idx == 0) || (idx == 3);
      in_last  = (idx == 2) || (idx == 4);
      in_data  = {8'(idx*4+4), 8'(idx*4+3), 8'(idx*4+2), 8'(idx*4+1)};
      acc_now  = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc_now) begin acc_e[idx] = c; idx++; end
      if (frame_done) begin
        if (first_done < 0) first_done = c;
        done_cnt++;
      end
      for (int i = 0; i < N; i++) begin
        if (out_valid[i]) begin
          if (out_first[i]) begin
            if (open[i]) viol[i]++;
            open[i] = 1;
          end else if (!open[i]) viol[i]++;
          if (out_last[i]) open[i] = 0;
        end
      end
    end
    in_valid = 0; in_first = 0; in_last = 0;
    chk("b2b_accepted",  idx, 5);
    chk("b2b_stream",    acc_e[1] - acc_e[0], 1);
    chk("b2b_gap",       acc_e[3] - acc_e[2], N);
    chk("b2b_done_cnt",  done_cnt, 2);
    chk("b2b_done_edge", first_done, acc_e[2] + N - 1);
    for (int i = 0; i < N; i++) chk($sformatf("b2b_order_lane%0d", i), viol[i], 0);

    // ---- reset mid-STREAM ----
    do_reset();
    in_valid = 1; in_first = 1; in_last = 0; in_data = 32'h44332211;
    mtick(ld);
    in_first = 0; in_data = 32'h88776655;
    mtick(ld);
    #2 rst = 1;
    #1;
    chk("mrst_data",  out_data,   '0);
    chk("mrst_valid", out_valid,  '0);
    chk("mrst_first", out_first,  '0);
    chk("mrst_last",  out_last,   '0);
    chk("mrst_done",  frame_done, 1'b0);
    chk("mrst_ready", in_ready,   1'b1);
    #2 rst = 0;
    model_reset();
    in_valid = 1; in_first = 1; in_last = 0; in_data = 32'hA4A3A2A1;
    mtick(ld);
    in_first = 0; in_last = 1; in_data = 32'hB4B3B2B1;
    mtick(ld);
    in_valid = 0; in_last = 0;
    repeat (6) mtick(ld);

    // ---- randomized backpressure against the model ----
    do_reset();
    beats = 0; cyc = 0; pos = 0; flen = $urandom_range(1, 4);
    while (beats < 10000 && cyc < 80000) begin
      in_valid = ($urandom_range(0, 9) < 7);
      in_first = (pos == 0) ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 9) == 0);
      in_last  = (pos == flen - 1);
      in_data  = $urandom;
      mtick(ld);
      cyc++;
      if (ld) begin
        beats++;
        if (in_last) begin pos = 0; flen = $urandom_range(1, 4); end
        else pos++;
      end
    end
    chk("rand_beats", beats, 10000);
    in_valid = 0;
    repeat (N + 1) mtick(ld);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
